hwpe_stream_sink_realign_pipe: RTL
==================================

HWPE_STREAM_SINK_REALIGN_PIPE -- requirements
Module: hwpe_stream_sink_realign_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream width in bits (multiple of 16, NB=DATA_WIDTH/8 bytes).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the word-count field.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clear_i  input  1  synchronous soft clear, same effect as rst_i.
REQ-006 SHALL have port start_i  input  1  transfer start pulse, sampled only in IDLE.
REQ-007 SHALL have port offset_i  input  $clog2(NB)  destination byte offset, latched on accepted start.
REQ-008 SHALL have port nwords_i  input  CNT_WIDTH  input word count, latched on accepted start.
REQ-009 SHALL have port busy_o  output  1  high while not IDLE.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse at transfer completion.
REQ-011 SHALL have port stream_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  aligned input words.
REQ-012 SHALL have port stream_o  hwpe_stream_intf_stream.source  DATA_WIDTH  realigned output words with byte strobes.

Function
REQ-013 SHALL implement FSM IDLE, RUN, FLUSH; start_i in IDLE with nwords_i>0 -> RUN; nwords_i==0 -> stay IDLE, done_o pulse next cycle, no beats.
REQ-014 SHALL ignore start_i outside IDLE.
REQ-015 SHALL count input handshakes in RUN; on the nwords-th handshake -> FLUSH if offset!=0, else IDLE with done_o.
REQ-016 SHALL in FLUSH emit exactly one beat, then on its handshake -> IDLE with done_o pulse that same following cycle.
REQ-017 SHALL emit nwords output beats when offset==0 and nwords+1 when offset!=0.
REQ-018 SHALL hold prev_data/prev_strb registers updated on every input handshake, cleared on accepted start.
REQ-019 SHALL form data = (in_data << 8*off) | (prev_data >> 8*(NB-off)); prev term forced to zero when off==0 (no full-width shift).
REQ-020 SHALL form strb: first beat in_strb<<off; later beats (in_strb<<off)|(prev_strb>>(NB-off)); flush beat prev_strb>>(NB-off); shifted-out bits truncated to NB.
REQ-021 SHALL drive stream_i.ready low in IDLE and FLUSH; no input consumed outside RUN.
REQ-022 SHALL obey valid/ready protocol: stream_o.valid, data, strb stable until handshake; valid never depends combinationally on stream_o.ready.
REQ-023 SHALL complete input and output handshakes in the same cycle when the skid feature is compiled out (stream_o.valid=stream_i.valid, stream_i.ready=stream_o.ready in RUN).

Reset
REQ-024 SHALL on rst_i or clear_i: FSM IDLE, counter 0, prev_data/prev_strb 0, stream_o.valid 0, stream_i.ready 0, busy_o 0, done_o 0.
REQ-025 SHALL abandon an in-flight transfer on reset/clear mid-operation with no done_o pulse; clear_i has priority over start_i.

Configuration
REQ-026 SHALL support macro HWPE_STREAM_REALIGN_SKID_EN.
REQ-027 SHALL with HWPE_STREAM_REALIGN_SKID_EN defined insert a 2-entry skid buffer on stream_o: output registered (+1 cycle latency), stream_i.ready = buffer not full, no combinational path stream_o.ready -> stream_i.ready; FSM leaves FLUSH/RUN only after skid empty, done_o after last beat leaves buffer.
REQ-028 SHALL without the macro be purely combinational from stream_i to stream_o per REQ-023, zero latency.

Verification
REQ-029 SHALL test offset 0, nwords 3, words A,B,C, strb F -> 3 beats A,B,C strb F, done_o once.
REQ-030 SHALL test DATA_WIDTH 32, offset 1, nwords 2, words 0x44332211, 0x88776655 -> 0x33221100/E, 0x77665544/F, 0x00000088/1, done_o.
REQ-031 SHALL test offset 3, nwords 1, word 0xDDCCBBAA -> 0xAA000000/8, then 0x00DDCCBB/7.
REQ-032 SHALL test random stream_o.ready stalls (50%) over offset 2, nwords 64 -> output identical to no-stall run, no beat dropped/duplicated, both macro settings.
REQ-033 SHALL test clear_i asserted mid-RUN after 5 of 10 words -> valid low next cycle, busy_o 0, no done_o; new start offset 0 nwords 1 completes normally.
REQ-034 SHALL test start_i with nwords_i 0 -> no stream_o.valid, done_o pulse one cycle later; start_i while busy -> ignored.

Source files
------------

// File: rtl/hwpe_stream_sink_realign_pipe.sv
// ---------------------------------------------------------------------------
// hwpe_stream_sink_realign_pipe
//
// Shifts a stream of aligned input words to a destination byte offset.
// Each output beat is the current input word shifted up by `off` bytes,
// OR'ed with the top bytes of the previous input word. If the offset is
// non-zero, one extra flush beat carries the tail of the last word. Byte
// strobes follow the same shift.
//
// Optional macro HWPE_STREAM_REALIGN_SKID_EN: adds a 2-entry skid buffer on
// the output side. The output becomes registered (+1 cycle latency) and
// stream_i_ready no longer depends combinationally on stream_o_ready.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   clear_i         synchronous soft clear, same effect as rst_i
//   start_i         transfer start, sampled only in IDLE
//   offset_i        destination byte offset, latched on start
//   nwords_i        number of input words, latched on start
//   busy_o          high while not IDLE
//   done_o          one-cycle completion pulse
//   stream_i_*      aligned input stream (valid/ready/data/strb)
//   stream_o_*      realigned output stream (valid/ready/data/strb)
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for start_i
// RUN   | consuming nwords input words
// FLUSH | emitting the tail beat (offset != 0 only)
// ---------------------------------------------------------------------------
module hwpe_stream_sink_realign_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned NB = DATA_WIDTH / 8,
    localparam int unsigned OW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [OW-1:0]         offset_i,
    input  logic [CNT_WIDTH-1:0]  nwords_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  stream_i_valid,
    output logic                  stream_i_ready,
    input  logic [DATA_WIDTH-1:0] stream_i_data,
    input  logic [NB-1:0]         stream_i_strb,
    output logic                  stream_o_valid,
    input  logic                  stream_o_ready,
    output logic [DATA_WIDTH-1:0] stream_o_data,
    output logic [NB-1:0]         stream_o_strb
);

    localparam int unsigned SW = OW + 4;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, nwords_q;
    logic [OW-1:0]         off_q;
    logic [DATA_WIDTH-1:0] prev_data_q;
    logic [NB-1:0]         prev_strb_q;
    logic                  done_q, done_d;
    logic                  flush_sent_q;
    logic                  start_acc, run_accept, in_hs;
    logic                  beat_valid, beat_ready;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [NB-1:0]         beat_strb;
    logic                  drained;

    logic [SW-1:0]         sh_in_bits, sh_prev_bits;
    logic [OW:0]           sh_prev_bytes;
    logic [DATA_WIDTH-1:0] shifted_in, prev_term;
    logic [NB-1:0]         strb_in, prev_strb_term;

    // With off == 0 the previous-word term would need a full-width shift;
    // it is forced to zero instead.
    assign sh_in_bits     = SW'({off_q, 3'b000});
    assign sh_prev_bits   = SW'(DATA_WIDTH) - sh_in_bits;
    assign sh_prev_bytes  = (OW+1)'(NB) - (OW+1)'(off_q);
    assign shifted_in     = stream_i_data << sh_in_bits;
    assign prev_term      = (off_q == '0) ? '0 : (prev_data_q >> sh_prev_bits);
    assign strb_in        = stream_i_strb << off_q;
    assign prev_strb_term = (off_q == '0) ? '0 : (prev_strb_q >> sh_prev_bytes);

    always_comb begin
        state_d        = state_q;
        done_d         = 1'b0;
        start_acc      = (state_q == IDLE) && start_i;
        run_accept     = (state_q == RUN) && (cnt_q != nwords_q);
        stream_i_ready = run_accept && beat_ready;
        in_hs          = stream_i_valid && stream_i_ready;
        beat_valid     = 1'b0;
        beat_data      = shifted_in | prev_term;
        beat_strb      = strb_in | prev_strb_term;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (nwords_i == '0) done_d  = 1'b1;
                    else                state_d = RUN;
                end
            end
            RUN: begin
                beat_valid = run_accept && stream_i_valid;
`ifdef HWPE_STREAM_REALIGN_SKID_EN
                // All words pushed; leave only once the buffer has drained.
                if (!run_accept && drained) begin
`else
                if (in_hs && ((cnt_q + 1'b1) == nwords_q)) begin
`endif
                    if (off_q != '0) state_d = FLUSH;
                    else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                beat_valid = !flush_sent_q;
                beat_data  = prev_term;
                beat_strb  = prev_strb_term;
`ifdef HWPE_STREAM_REALIGN_SKID_EN
                if (flush_sent_q && drained) begin
`else
                if (beat_valid && beat_ready) begin
`endif
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            nwords_q     <= '0;
            off_q        <= '0;
            prev_data_q  <= '0;
            prev_strb_q  <= '0;
            flush_sent_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (start_acc) begin
                off_q        <= offset_i;
                nwords_q     <= nwords_i;
                cnt_q        <= '0;
                prev_data_q  <= '0;
                prev_strb_q  <= '0;
                flush_sent_q <= 1'b0;
            end else begin
                if (in_hs) begin
                    cnt_q       <= cnt_q + 1'b1;
                    prev_data_q <= stream_i_data;
                    prev_strb_q <= stream_i_strb;
                end
                if ((state_q == FLUSH) && beat_valid && beat_ready)
                    flush_sent_q <= 1'b1;
            end
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

`ifdef HWPE_STREAM_REALIGN_SKID_EN
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [NB-1:0]         fifo_strb_q [2];
    logic                  wr_q, rd_q;
    logic [1:0]            fill_q;
    logic                  push, pop;

    // Ready is taken from the registered fill level only, never from
    // stream_o_ready; a full buffer refuses a push even if it pops.
    assign beat_ready = (fill_q != 2'd2);
    assign push       = beat_valid && beat_ready;
    assign pop        = stream_o_valid && stream_o_ready;
    assign drained    = (fill_q == 2'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_q           <= 1'b0;
            rd_q           <= 1'b0;
            fill_q         <= 2'd0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_strb_q[0] <= '0;
            fifo_strb_q[1] <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_q] <= beat_data;
                fifo_strb_q[wr_q] <= beat_strb;
                wr_q              <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 2'd1;
                2'b01:   fill_q <= fill_q - 2'd1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign stream_o_valid = (fill_q != 2'd0);
    assign stream_o_data  = fifo_data_q[rd_q];
    assign stream_o_strb  = fifo_strb_q[rd_q];
`else
    assign beat_ready     = stream_o_ready;
    assign drained        = 1'b1;
    assign stream_o_valid = beat_valid;
    assign stream_o_data  = beat_data;
    assign stream_o_strb  = beat_strb;
`endif

endmodule
